// File: rtl/sevenseg_capture_pkg.sv
// Shared constants for the seven-segment display path: active-low glyph
// patterns (bit 6 = g ... bit 0 = a, 0 = lit) and the special digit codes.
package sevenseg_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

  // Width of the stability counter; large enough for STABLE_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/sevenseg_capture_decode.sv
// Combinational inverse of the seven-segment encoder: pattern -> digit + err.
module sevenseg_decode
  import sevenseg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       err
);

  // Table lookup; anything that is not a known glyph decodes to DIGIT_ERR.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    digit = DIGIT_ERR;
    err   = 1'b1;
    unique case (seg)
      SEG_0:     begin digit = 4'h0;        err = 1'b0; end
      SEG_1:     begin digit = 4'h1;        err = 1'b0; end
      SEG_2:     begin digit = 4'h2;        err = 1'b0; end
      SEG_3:     begin digit = 4'h3;        err = 1'b0; end
      SEG_4:     begin digit = 4'h4;        err = 1'b0; end
      SEG_5:     begin digit = 4'h5;        err = 1'b0; end
      SEG_6:     begin digit = 4'h6;        err = 1'b0; end
      SEG_7:     begin digit = 4'h7;        err = 1'b0; end
      SEG_8:     begin digit = 4'h8;        err = 1'b0; end
      SEG_9:     begin digit = 4'h9;        err = 1'b0; end
      SEG_BLANK: begin digit = DIGIT_BLANK; err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Monitors a multiplexed active-low segment bus, debounces each digit's
// pattern, keeps a decoded per-digit snapshot and reports changes through a
// single-entry valid/ready event register.
module sevenseg_capture
  import sevenseg_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SEL_W         = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [6:0]              seg_in,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    seg_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_index,
  output logic [3:0]              out_digit,
  output logic                    out_err,
  output logic [4*NUM_DIGITS-1:0] snapshot,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    overflow
);

  localparam logic [CNT_W-1:0] STABLE     = CNT_W'(STABLE_CYCLES);
  localparam logic [SEL_W:0]   DIGITS_LIM = (SEL_W+1)'(NUM_DIGITS);
  localparam bit               ONE_SHOT   = (STABLE_CYCLES == 1);

  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last_sel;
  logic [6:0]       last_seg;
  logic [3:0]       dec_digit;
  logic             dec_err;
  logic             in_range;
  logic             qualified;
  logic             same;
  logic             commit;
  logic             change;

  sevenseg_decode u_decode (
    .seg   (seg_in),
    .digit (dec_digit),
    .err   (dec_err)
  );

  assign in_range  = ({1'b0, sel_in} < DIGITS_LIM);
  assign qualified = seg_valid && in_range;
  assign same      = (sel_in == last_sel) && (seg_in == last_seg);

  // Commit exactly when the counter reaches STABLE: either the matching sample
  // that completes the run, or any fresh sample when one sample suffices.
  // A saturated counter (cnt == STABLE) never commits again.
  assign commit = qualified && (same ? (cnt == STABLE - 1'b1) : ONE_SHOT);
  assign change = commit &&
                  ({dec_digit, dec_err} != {snapshot[4*sel_in +: 4], err_mask[sel_in]});

  // Stability tracking: count consecutive identical qualified samples.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      cnt      <= '0;
      last_sel <= '0;
      last_seg <= '0;
    end else if (seg_valid) begin
      if (!in_range) begin
        cnt <= '0;
      end else if (same) begin
        if (cnt != STABLE) cnt <= cnt + 1'b1;
      end else begin
        last_sel <= sel_in;
        last_seg <= seg_in;
        cnt      <= CNT_W'(1);
      end
    end
  end

  // Snapshot and error mask, updated on every commit whether or not an event fits.
  always_ff @(posedge clock or negedge resetn) begin
    // NOTE: this storage is reset because its blank contents are architecturally visible.
    if (!resetn) begin
      snapshot <= '1;
      err_mask <= '0;
    end else if (commit) begin
      snapshot[4*sel_in +: 4] <= dec_digit;
      err_mask[sel_in]        <= dec_err;
    end
  end

  // Single-entry event register with back-to-back load and sticky overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_digit <= DIGIT_BLANK;
      out_err   <= 1'b0;
      overflow  <= 1'b0;
    end else if (change && (!out_valid || out_ready)) begin
      out_valid <= 1'b1;
      out_index <= sel_in;
      out_digit <= dec_digit;
      out_err   <= dec_err;
    end else if (change) begin
      overflow <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: stimulus pushes expected events into a
// queue, a negedge monitor pops and compares on every accepted event.
module tb_sevenseg_capture;

  logic        clock = 1'b0;
  logic        resetn;
  logic [6:0]  seg_in;
  logic [2:0]  sel_in;
  logic        seg_valid;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_index;
  logic [3:0]  out_digit;
  logic        out_err;
  logic [31:0] snapshot;
  logic [7:0]  err_mask;
  logic        overflow;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] digit;
    logic       err;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  errors  = 0;

  sevenseg_capture #(.NUM_DIGITS(8), .SEL_W(3), .STABLE_CYCLES(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .seg_in    (seg_in),
    .sel_in    (sel_in),
    .seg_valid (seg_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_digit (out_digit),
    .out_err   (out_err),
    .snapshot  (snapshot),
    .err_mask  (err_mask),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input logic [3:0] digit, input logic err);
    ev_t e;
    e.idx   = idx;
    e.digit = digit;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Present one qualified sample per clock for n clocks.
  task automatic drive(input logic [2:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      sel_in    = sel;
      seg_in    = seg;
      seg_valid = 1'b1;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    seg_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: each negedge with valid && ready is one acceptance at the next edge.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_event: got idx=%0d digit=%0h err=%0b expected none",
                   out_index, out_digit, out_err);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event", 32'({out_index, out_digit, out_err}), 32'({e.idx, e.digit, e.err}));
        end
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    seg_in    = 7'h00;
    sel_in    = 3'd0;
    seg_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // Reset state after idling.
    idle(20);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_snapshot",  snapshot,       32'hFFFF_FFFF);
    check("reset_err_mask",  32'(err_mask),  32'h0);
    check("reset_overflow",  32'(overflow),  32'h0);
    check("reset_out_digit", 32'(out_digit), 32'hF);

    // Digit 2 at position 2; holding it longer must not re-raise.
    push(3'd2, 4'h2, 1'b0);
    drive(3'd2, 7'h24, 4);
    check("snap2_after_commit", 32'(snapshot[11:8]), 32'h2);
    drive(3'd2, 7'h24, 4);
    idle(2);
    check("snap2_still", 32'(snapshot[11:8]), 32'h2);

    // Alternating pattern never stabilises; then a held 5 commits.
    for (int r = 0; r < 2; r++) begin
      drive(3'd5, 7'h19, 2);
      drive(3'd5, 7'h12, 2);
    end
    drive(3'd5, 7'h19, 2);
    check("snap5_no_commit", 32'(snapshot[23:20]), 32'hF);
    push(3'd5, 4'h5, 1'b0);
    drive(3'd5, 7'h12, 4);
    check("snap5_commit", 32'(snapshot[23:20]), 32'h5);
    idle(2);

    // Stalled consumer: first event held, second dropped, snapshot updated.
    out_ready = 1'b0;
    push(3'd0, 4'h3, 1'b0);
    drive(3'd0, 7'h30, 4);
    drive(3'd1, 7'h78, 4);
    idle(1);
    check("stall_out_valid", 32'(out_valid), 32'h1);
    check("stall_out_digit", 32'(out_digit), 32'h3);
    check("stall_out_index", 32'(out_index), 32'h0);
    check("stall_overflow",  32'(overflow),  32'h1);
    check("stall_snap1",     32'(snapshot[7:4]), 32'h7);
    check("stall_snap0",     32'(snapshot[3:0]), 32'h3);
    out_ready = 1'b1;
    idle(2);
    check("stall_drained", 32'(out_valid), 32'h0);

    // Illegal glyph then blank on position 4.
    push(3'd4, 4'hE, 1'b1);
    drive(3'd4, 7'h55, 4);
    check("err_mask_set", 32'(err_mask[4]), 32'h1);
    check("snap4_err",    32'(snapshot[19:16]), 32'hE);
    push(3'd4, 4'hF, 1'b0);
    drive(3'd4, 7'h7F, 4);
    check("err_mask_clear", 32'(err_mask[4]), 32'h0);
    idle(2);
    check("overflow_sticky", 32'(overflow), 32'h1);

    // Reset mid-count: everything back to reset values at once.
    drive(3'd6, 7'h02, 3);
    #2 resetn = 1'b0;
    #1;
    check("rst1_out_valid", 32'(out_valid), 32'h0);
    check("rst1_out_index", 32'(out_index), 32'h0);
    check("rst1_out_digit", 32'(out_digit), 32'hF);
    check("rst1_out_err",   32'(out_err),   32'h0);
    check("rst1_snapshot",  snapshot,       32'hFFFF_FFFF);
    check("rst1_err_mask",  32'(err_mask),  32'h0);
    check("rst1_overflow",  32'(overflow),  32'h0);
    seg_valid = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    drive(3'd6, 7'h02, 1);
    idle(4);
    check("rst1_no_event", 32'(out_valid), 32'h0);
    check("rst1_snap6",    32'(snapshot[27:24]), 32'hF);

    // Reset mid-stall: pending event discarded.
    out_ready = 1'b0;
    push(3'd3, 4'h9, 1'b0);
    drive(3'd3, 7'h10, 4);
    idle(1);
    check("rst2_pre_valid", 32'(out_valid), 32'h1);
    check("rst2_pre_digit", 32'(out_digit), 32'h9);
    #2 resetn = 1'b0;
    exp_q.delete();
    #1;
    check("rst2_out_valid", 32'(out_valid), 32'h0);
    check("rst2_snapshot",  snapshot,       32'hFFFF_FFFF);
    check("rst2_overflow",  32'(overflow),  32'h0);
    @(posedge clock);
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    drive(3'd3, 7'h10, 1);
    idle(4);
    check("rst2_no_event", 32'(out_valid), 32'h0);
    check("rst2_snap3",    32'(snapshot[15:12]), 32'hF);

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_capture.md
Name: sevenseg_capture

Overview:
- Reverse direction of the seven-segment encoder. Samples a multiplexed active-low segment bus (digit select plus 7-bit pattern) and debounces each pattern.
- Decodes each stable pattern back to a 4-bit digit and keeps a per-digit snapshot.
- Emits change events through a valid/ready port.
- Used as a self-check monitor on the display path of the pipelined CPU's debug output.

Parameters:
- NUM_DIGITS, 8, number of display positions tracked.
- SEL_W, 3, width of the digit-select bus; must satisfy 2**SEL_W >= NUM_DIGITS.
- STABLE_CYCLES, 4, consecutive identical qualified samples required before a pattern is committed; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment pattern, bit 6 = segment g … bit 0 = segment a; 0 = lit.
- sel_in  in  SEL_W  index of the digit currently driven on seg_in.
- seg_valid  in  1  sample qualifier; seg_in/sel_in are ignored when low.
- out_valid  out  1  change event available.
- out_ready  in  1  consumer accepts the event when out_valid && out_ready at a clock edge.
- out_index  out  SEL_W  digit position of the event.
- out_digit  out  4  decoded value.
- out_err  out  1  event pattern was not a legal glyph.
- snapshot  out  4*NUM_DIGITS  committed digit per position; position i occupies [4i+3:4i].
- err_mask  out  NUM_DIGITS  bit i set while position i holds an illegal pattern.
- overflow  out  1  sticky; an event was lost. Cleared only by reset.

Behaviour:
- Reset (resetn low, asynchronous):
  - out_valid=0, out_index=0, out_digit=0xF, out_err=0.
  - every snapshot nibble = 0xF (blank), err_mask=0, overflow=0.
  - stability counter = 0, last-sample register = 0.
  - Reset mid-count or mid-handshake discards all pending state. No event is emitted on reset release.
- Decode table (exact inverse of the encoder):
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F→0xF (blank), legal, err=0.
  - Any other pattern → digit 0xE, err=1.
- Stability tracking, on each edge with seg_valid=1 and sel_in < NUM_DIGITS:
  - If {sel_in,seg_in} equals the last sample, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the last sample is loaded and the counter is set to 1.
  - seg_valid=0: no change. sel_in >= NUM_DIGITS: sample ignored and counter cleared to 0.
- Commit, on the edge where the counter transitions to STABLE_CYCLES:
  - Covers both the N-th matching sample and the first sample when STABLE_CYCLES=1.
  - A saturated counter never re-commits.
  - snapshot[sel_in] and err_mask[sel_in] are updated at that edge.
  - If the decoded {digit,err} differs from the prior snapshot/err_mask entry, a change event is raised. Re-committing an identical value raises nothing.
- Event register (single entry), at each edge:
  - Event raised and (out_valid=0, or out_ready=1): load out_* and hold out_valid=1. Simultaneous accept and new event gives a back-to-back load with no bubble and no overflow.
  - Event raised while out_valid=1 and out_ready=0: event dropped, overflow set, out_* unchanged. The snapshot is still updated.
  - No event, out_valid && out_ready: out_valid=0.
- Latency: event visible on out_* in the cycle after the committing edge.
- out_* stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package: segment pattern constants SEG_0..SEG_9 and SEG_BLANK (shared with the encoder), DIGIT_BLANK=4'hF, DIGIT_ERR=4'hE.
- One combinational sub-module, sevenseg_decode (7-bit pattern → 4-bit digit + err), instantiated once on the sample path.

Test Plan:
- Reset then idle 20 cycles → out_valid=0, snapshot all 0xF, err_mask=0, overflow=0.
- sel=2, seg=0x24, seg_valid=1 for 4 cycles, out_ready=1 → out_valid=1 for one cycle after the 4th edge; out_index=2, out_digit=2, out_err=0; snapshot[11:8]=2. Continuing the same sample yields no further event.
- sel=5 alternating seg=0x19/0x12 every 2 cycles → no commit, no event. Then seg=0x12 held 4 cycles → event index 5, digit 5.
- out_ready=0; commit idx0=3 (seg 0x30) then idx1=7 (seg 0x78) → first event held (digit 3), overflow=1, snapshot[7:4]=7. Raise out_ready → out_valid drops after one accept.
- sel=4, seg=0x55 held 4 cycles → event digit 0xE, out_err=1, err_mask[4]=1. Then seg=0x7F held 4 cycles → event digit 0xF, err_mask[4]=0.
- Assert resetn low mid-count (after 3 matching samples) and mid-stall (out_valid=1, out_ready=0) → all outputs at reset values immediately; after release, one further matching sample gives no event.
